// File: rtl/memory_stage_if.sv
// Signal bundle between execute, data memory, writeback and memory_stage.
// Widths and load/store opcodes come from REG_WIDTH, OPCODE_WIDTH, OP_LDW, OP_STW.
`ifndef REG_WIDTH
`define REG_WIDTH 16
`endif
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 8
`endif
`ifndef OP_LDW
`define OP_LDW 8'h20
`endif
`ifndef OP_STW
`define OP_STW 8'h21
`endif

interface memory_stage_if;
  logic                     I_LOCK;
  logic [`REG_WIDTH-1:0]    I_ALUOut;
  logic [`OPCODE_WIDTH-1:0] I_Opcode;
  logic [3:0]               I_DestRegIdx;
  logic [`REG_WIDTH-1:0]    I_DestValue;
  logic                     I_FetchStall;
  logic                     I_DepStall;
  logic                     I_DMemAck;
  logic [`REG_WIDTH-1:0]    I_DMemRData;
  logic                     O_DMemReq;
  logic                     O_DMemWe;
  logic [`REG_WIDTH-1:0]    O_DMemAddr;
  logic [`REG_WIDTH-1:0]    O_DMemWData;
  logic                     O_LOCK;
  logic                     O_FetchStall;
  logic                     O_DepStall;
  logic [`REG_WIDTH-1:0]    O_ALUOut;
  logic [`REG_WIDTH-1:0]    O_MemOut;
  logic [`OPCODE_WIDTH-1:0] O_Opcode;
  logic [3:0]               O_DestRegIdx;
  logic                     O_MemStall;
  logic                     O_MemErr;

  modport master (
    output I_LOCK, I_ALUOut, I_Opcode, I_DestRegIdx, I_DestValue,
           I_FetchStall, I_DepStall, I_DMemAck, I_DMemRData,
    input  O_DMemReq, O_DMemWe, O_DMemAddr, O_DMemWData, O_LOCK,
           O_FetchStall, O_DepStall, O_ALUOut, O_MemOut, O_Opcode,
           O_DestRegIdx, O_MemStall, O_MemErr
  );

  modport slave (
    input  I_LOCK, I_ALUOut, I_Opcode, I_DestRegIdx, I_DestValue,
           I_FetchStall, I_DepStall, I_DMemAck, I_DMemRData,
    output O_DMemReq, O_DMemWe, O_DMemAddr, O_DMemWData, O_LOCK,
           O_FetchStall, O_DepStall, O_ALUOut, O_MemOut, O_Opcode,
           O_DestRegIdx, O_MemStall, O_MemErr
  );
endinterface

// File: rtl/memory_stage.sv
// Pipeline memory stage: forwards ALU results, runs LDW/STW through a req/ack port.
// Optional ack timeout is enabled by defining MEM_STAGE_TIMEOUT_EN.
`ifndef REG_WIDTH
`define REG_WIDTH 16
`endif
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 8
`endif
`ifndef OP_LDW
`define OP_LDW 8'h20
`endif
`ifndef OP_STW
`define OP_STW 8'h21
`endif

module memory_stage #(
  parameter int ACK_TIMEOUT = 16
) (
  input logic           I_CLOCK,
  input logic           I_RESET,
  memory_stage_if.slave io_bus
);
  localparam int RW = `REG_WIDTH;
  localparam int OW = `OPCODE_WIDTH;
  localparam logic [OW-1:0] OPC_LDW = OW'(`OP_LDW);
  localparam logic [OW-1:0] OPC_STW = OW'(`OP_STW);

  if (ACK_TIMEOUT < 1) begin : g_bad_timeout
    $error("ACK_TIMEOUT must be at least 1");
  end

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t          r_state;
  logic            r_req, r_we, r_lock, r_fs, r_ds, r_mstall;
  logic [RW-1:0]   r_addr, r_wdata, r_alu, r_mem;
  logic [OW-1:0]   r_op, r_hold_op;
  logic [3:0]      r_dest, r_hold_dest;

  logic w_go, w_is_mem, w_expire;
  assign w_go     = io_bus.I_LOCK & ~io_bus.I_FetchStall & ~io_bus.I_DepStall;
  assign w_is_mem = (io_bus.I_Opcode == OPC_LDW) || (io_bus.I_Opcode == OPC_STW);

`ifdef MEM_STAGE_TIMEOUT_EN
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  logic [CW-1:0] r_cnt;
  logic          r_err;

  // Idle holds the counter at zero, so every WAIT entry starts a fresh count
  assign w_expire = (r_state == S_WAIT) && !io_bus.I_DMemAck &&
                    (r_cnt == CW'(ACK_TIMEOUT - 1));

  always_ff @(negedge I_CLOCK) begin
    if (I_RESET || r_state == S_IDLE) r_cnt <= '0;
    else if (!io_bus.I_DMemAck)       r_cnt <= r_cnt + 1'b1;
    if (I_RESET) r_err <= 1'b0;
    else         r_err <= w_expire;
  end

  assign io_bus.O_MemErr = r_err;
`else
  assign w_expire        = 1'b0;
  assign io_bus.O_MemErr = 1'b0;
`endif

  always_ff @(negedge I_CLOCK) begin
    if (I_RESET) begin
      r_state     <= S_IDLE;
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_lock      <= 1'b0;
      r_fs        <= 1'b0;
      r_ds        <= 1'b0;
      r_mstall    <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_alu       <= '0;
      r_mem       <= '0;
      r_op        <= '0;
      r_dest      <= '0;
      r_hold_op   <= '0;
      r_hold_dest <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_lock   <= io_bus.I_LOCK;
          r_fs     <= io_bus.I_FetchStall;
          r_ds     <= io_bus.I_DepStall;
          r_req    <= 1'b0;
          r_we     <= 1'b0;
          r_mstall <= 1'b0;
          if (w_go && w_is_mem) begin
            // Issue edge emits a bubble; the op retires on the ack edge
            r_req       <= 1'b1;
            r_we        <= (io_bus.I_Opcode == OPC_STW);
            r_addr      <= io_bus.I_ALUOut;
            r_wdata     <= io_bus.I_DestValue;
            r_mstall    <= 1'b1;
            r_ds        <= 1'b1;
            r_hold_op   <= io_bus.I_Opcode;
            r_hold_dest <= io_bus.I_DestRegIdx;
            r_state     <= S_WAIT;
          end else if (w_go) begin
            r_alu  <= io_bus.I_ALUOut;
            r_op   <= io_bus.I_Opcode;
            r_dest <= io_bus.I_DestRegIdx;
          end
        end
        S_WAIT: begin
          r_lock <= 1'b1;
          r_ds   <= 1'b1;
          if (io_bus.I_DMemAck) begin
            r_req    <= 1'b0;
            r_we     <= 1'b0;
            r_mstall <= 1'b0;
            r_ds     <= 1'b0;
            r_op     <= r_hold_op;
            r_dest   <= r_hold_dest;
            if (r_hold_op == OPC_LDW) r_mem <= io_bus.I_DMemRData;
            r_state  <= S_IDLE;
          end else if (w_expire) begin
            r_req    <= 1'b0;
            r_we     <= 1'b0;
            r_mstall <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_bus.O_DMemReq    = r_req;
  assign io_bus.O_DMemWe     = r_we;
  assign io_bus.O_DMemAddr   = r_addr;
  assign io_bus.O_DMemWData  = r_wdata;
  assign io_bus.O_LOCK       = r_lock;
  assign io_bus.O_FetchStall = r_fs;
  assign io_bus.O_DepStall   = r_ds;
  assign io_bus.O_ALUOut     = r_alu;
  assign io_bus.O_MemOut     = r_mem;
  assign io_bus.O_Opcode     = r_op;
  assign io_bus.O_DestRegIdx = r_dest;
  assign io_bus.O_MemStall   = r_mstall;
endmodule

// File: tb/tb_memory_stage.sv
// Testbench for memory_stage: directed scenarios plus random traffic against a
// transaction-level model; honours MEM_STAGE_TIMEOUT_EN like the design.
`ifndef REG_WIDTH
`define REG_WIDTH 16
`endif
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 8
`endif
`ifndef OP_LDW
`define OP_LDW 8'h20
`endif
`ifndef OP_STW
`define OP_STW 8'h21
`endif

module tb_memory_stage;
  localparam int TO = 4;
  localparam logic [`OPCODE_WIDTH-1:0] LDW  = `OPCODE_WIDTH'(`OP_LDW);
  localparam logic [`OPCODE_WIDTH-1:0] STW  = `OPCODE_WIDTH'(`OP_STW);
  localparam logic [`OPCODE_WIDTH-1:0] ADDI = `OPCODE_WIDTH'(8'h01);
`ifdef MEM_STAGE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b1;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  memory_stage_if bus();

  memory_stage #(.ACK_TIMEOUT(TO)) dut (
    .I_CLOCK (clk),
    .I_RESET (rst),
    .io_bus  (bus)
  );

  int n_vec  = 0;
  int n_fail = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: one outstanding memory transaction at most
  bit                       model_ok = 1'b0;
  bit                       busy = 1'b0;
  int                       age = 0;
  logic [`OPCODE_WIDTH-1:0] p_op;
  logic [3:0]               p_dest;
  logic                     e_req, e_we, e_lock, e_fs, e_ds, e_ms, e_err;
  logic [`REG_WIDTH-1:0]    e_addr, e_wd, e_alu, e_mem;
  logic [`OPCODE_WIDTH-1:0] e_op;
  logic [3:0]               e_dest;

  task automatic model_step();
    if (rst) begin
      {e_req, e_we, e_lock, e_fs, e_ds, e_ms, e_err} = '0;
      e_addr = '0; e_wd = '0; e_alu = '0; e_mem = '0; e_op = '0; e_dest = '0;
      busy = 1'b0; age = 0; p_op = '0; p_dest = '0;
      model_ok = 1'b1;
    end else if (!model_ok) begin
      // outputs undefined until the first reset edge
    end else if (!busy) begin
      e_lock = bus.I_LOCK; e_fs = bus.I_FetchStall; e_ds = bus.I_DepStall;
      e_req = 1'b0; e_we = 1'b0; e_ms = 1'b0; e_err = 1'b0;
      if (bus.I_LOCK && !bus.I_FetchStall && !bus.I_DepStall) begin
        if (bus.I_Opcode == LDW || bus.I_Opcode == STW) begin
          e_req = 1'b1; e_we = (bus.I_Opcode == STW);
          e_addr = bus.I_ALUOut; e_wd = bus.I_DestValue;
          e_ms = 1'b1; e_ds = 1'b1;
          busy = 1'b1; age = 0; p_op = bus.I_Opcode; p_dest = bus.I_DestRegIdx;
        end else begin
          e_alu = bus.I_ALUOut; e_op = bus.I_Opcode; e_dest = bus.I_DestRegIdx;
        end
      end
    end else begin
      e_lock = 1'b1; e_ds = 1'b1; e_err = 1'b0;
      if (bus.I_DMemAck) begin
        e_req = 1'b0; e_we = 1'b0; e_ms = 1'b0; e_ds = 1'b0;
        e_op = p_op; e_dest = p_dest;
        if (p_op == LDW) e_mem = bus.I_DMemRData;
        busy = 1'b0;
      end else begin
        age++;
        if (TO_EN && age >= TO) begin
          e_req = 1'b0; e_we = 1'b0; e_ms = 1'b0; e_err = 1'b1;
          busy = 1'b0;
        end
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    model_step();
  end

  initial forever begin
    @(posedge clk);
    if (model_ok) begin
      cmp("O_DMemReq",    bus.O_DMemReq,    e_req);
      cmp("O_DMemWe",     bus.O_DMemWe,     e_we);
      cmp("O_DMemAddr",   bus.O_DMemAddr,   e_addr);
      cmp("O_DMemWData",  bus.O_DMemWData,  e_wd);
      cmp("O_LOCK",       bus.O_LOCK,       e_lock);
      cmp("O_FetchStall", bus.O_FetchStall, e_fs);
      cmp("O_DepStall",   bus.O_DepStall,   e_ds);
      cmp("O_ALUOut",     bus.O_ALUOut,     e_alu);
      cmp("O_MemOut",     bus.O_MemOut,     e_mem);
      cmp("O_Opcode",     bus.O_Opcode,     e_op);
      cmp("O_DestRegIdx", bus.O_DestRegIdx, e_dest);
      cmp("O_MemStall",   bus.O_MemStall,   e_ms);
      cmp("O_MemErr",     bus.O_MemErr,     e_err);
    end
  end

  task automatic put(input logic lock, input logic [`OPCODE_WIDTH-1:0] op,
                     input logic [`REG_WIDTH-1:0] alu, input logic [3:0] dest,
                     input logic [`REG_WIDTH-1:0] val, input logic fs, input logic ds,
                     input logic ack, input logic [`REG_WIDTH-1:0] rdata);
    bus.I_LOCK = lock; bus.I_Opcode = op; bus.I_ALUOut = alu;
    bus.I_DestRegIdx = dest; bus.I_DestValue = val;
    bus.I_FetchStall = fs; bus.I_DepStall = ds;
    bus.I_DMemAck = ack; bus.I_DMemRData = rdata;
  endtask

  // One falling (active) edge, then settle just past the following rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ack_pct;
    put(0, '0, '0, '0, '0, 0, 0, 0, '0);
    rst = 1'b1;
    tick(); tick();
    cmp("reset_req",    bus.O_DMemReq,  1'b0);
    cmp("reset_lock",   bus.O_LOCK,     1'b0);
    cmp("reset_aluout", bus.O_ALUOut,   16'h0);
    cmp("reset_mstall", bus.O_MemStall, 1'b0);
    cmp("reset_err",    bus.O_MemErr,   1'b0);

    // ALU forwarding
    rst = 1'b0;
    put(1, ADDI, 16'h0005, 4'd3, 16'h0, 0, 0, 0, '0);
    tick();
    cmp("addi_aluout", bus.O_ALUOut, 16'h0005);
    cmp("addi_dest",   bus.O_DestRegIdx, 4'd3);
    cmp("addi_dep",    bus.O_DepStall, 1'b0);
    cmp("addi_req",    bus.O_DMemReq, 1'b0);
    cmp("addi_lock",   bus.O_LOCK, 1'b1);

    // Load with ack on the fourth edge
    put(1, LDW, 16'h0010, 4'd7, 16'h5555, 0, 0, 0, 16'h0);
    tick();
    cmp("ldw_req",    bus.O_DMemReq, 1'b1);
    cmp("ldw_addr",   bus.O_DMemAddr, 16'h0010);
    cmp("ldw_we",     bus.O_DMemWe, 1'b0);
    cmp("ldw_stall1", bus.O_MemStall, 1'b1);
    tick();
    cmp("ldw_stall2", bus.O_MemStall, 1'b1);
    tick();
    cmp("ldw_stall3", bus.O_MemStall, 1'b1);
    bus.I_DMemAck = 1'b1; bus.I_DMemRData = 16'hBEEF;
    tick();
    cmp("ldw_stall_off", bus.O_MemStall, 1'b0);
    cmp("ldw_memout",    bus.O_MemOut, 16'hBEEF);
    cmp("ldw_dest",      bus.O_DestRegIdx, 4'd7);
    cmp("ldw_opcode",    bus.O_Opcode, LDW);
    cmp("ldw_req_off",   bus.O_DMemReq, 1'b0);

    // Store with immediate ack
    put(1, STW, 16'h0020, 4'd9, 16'h1234, 0, 0, 0, 16'h0);
    tick();
    cmp("stw_we",    bus.O_DMemWe, 1'b1);
    cmp("stw_wdata", bus.O_DMemWData, 16'h1234);
    cmp("stw_addr",  bus.O_DMemAddr, 16'h0020);
    put(0, '0, '0, '0, '0, 0, 0, 1, 16'h0BAD);
    tick();
    cmp("stw_we_off", bus.O_DMemWe, 1'b0);
    cmp("stw_opcode", bus.O_Opcode, STW);
    cmp("stw_memout", bus.O_MemOut, 16'hBEEF);

    // Ack while idle is ignored
    put(0, '0, '0, '0, '0, 0, 0, 1, 16'hDEAD);
    tick();
    cmp("idle_ack_req", bus.O_DMemReq, 1'b0);
    cmp("idle_ack_mem", bus.O_MemOut, 16'hBEEF);

    // Dependency stall blocks a load
    put(1, LDW, 16'h0030, 4'd2, 16'h0, 0, 1, 0, 16'h0);
    tick();
    cmp("dep_req", bus.O_DMemReq, 1'b0);
    cmp("dep_fwd", bus.O_DepStall, 1'b1);

    // Reset in the middle of a load
    put(1, LDW, 16'h0040, 4'd4, 16'h0, 0, 0, 0, 16'h0);
    tick();
    cmp("rstw_req", bus.O_DMemReq, 1'b1);
    tick(); tick();
    rst = 1'b1;
    tick();
    cmp("rstw_req_off", bus.O_DMemReq, 1'b0);
    cmp("rstw_lock",    bus.O_LOCK, 1'b0);
    cmp("rstw_memout",  bus.O_MemOut, 16'h0);
    rst = 1'b0;
    put(0, '0, '0, '0, '0, 0, 0, 1, 16'h7777);
    tick();
    cmp("rstw_late_ack", bus.O_MemOut, 16'h0);
    cmp("rstw_mstall",   bus.O_MemStall, 1'b0);

`ifdef MEM_STAGE_TIMEOUT_EN
    // Abort after TO ack-less wait edges
    put(1, LDW, 16'h0050, 4'd5, 16'h0, 0, 0, 0, 16'h0);
    tick();
    tick(); tick(); tick();
    cmp("to_err_early", bus.O_MemErr, 1'b0);
    cmp("to_req_held",  bus.O_DMemReq, 1'b1);
    tick();
    cmp("to_err",    bus.O_MemErr, 1'b1);
    cmp("to_req",    bus.O_DMemReq, 1'b0);
    cmp("to_dep",    bus.O_DepStall, 1'b1);
    cmp("to_mstall", bus.O_MemStall, 1'b0);
    put(0, '0, '0, '0, '0, 0, 0, 0, 16'h0);
    tick();
    cmp("to_err_pulse", bus.O_MemErr, 1'b0);
    // Ack on the expiry edge wins
    put(1, LDW, 16'h0060, 4'd6, 16'h0, 0, 0, 0, 16'h0);
    tick();
    tick(); tick(); tick();
    bus.I_DMemAck = 1'b1; bus.I_DMemRData = 16'hCAFE;
    tick();
    cmp("to_ack_err", bus.O_MemErr, 1'b0);
    cmp("to_ack_mem", bus.O_MemOut, 16'hCAFE);
    put(0, '0, '0, '0, '0, 0, 0, 0, 16'h0);
    tick();
`else
    // Without the timeout a load waits indefinitely for its ack
    put(1, LDW, 16'h0050, 4'd5, 16'h0, 0, 0, 0, 16'h0);
    tick();
    repeat (6) tick();
    cmp("noto_req",    bus.O_DMemReq, 1'b1);
    cmp("noto_mstall", bus.O_MemStall, 1'b1);
    cmp("noto_err",    bus.O_MemErr, 1'b0);
    bus.I_DMemAck = 1'b1; bus.I_DMemRData = 16'hCAFE;
    tick();
    cmp("noto_mem", bus.O_MemOut, 16'hCAFE);
    put(0, '0, '0, '0, '0, 0, 0, 0, 16'h0);
    tick();
`endif

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [`OPCODE_WIDTH-1:0] op;
      int sel;
      ack_pct = (i / 500) % 2 == 0 ? 5 : 1;
      sel = int'($urandom_range(0, 3));
      op  = (sel == 0) ? LDW : (sel == 1) ? STW : `OPCODE_WIDTH'($urandom);
      rst = ($urandom_range(0, 99) < 2);
      put($urandom_range(0, 9) < 8, op, `REG_WIDTH'($urandom), 4'($urandom),
          `REG_WIDTH'($urandom), $urandom_range(0, 9) < 1, $urandom_range(0, 9) < 1,
          $urandom_range(0, 9) < ack_pct, `REG_WIDTH'($urandom));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 16: falling edges in WAIT without I_DMemAck before abort (used only with MEM_STAGE_TIMEOUT_EN).
REQ-002 SHALL have I_CLOCK  in  1  clock; all state updates on its falling edge.
REQ-003 SHALL have I_RESET  in  1  reset; synchronous, active-high.
REQ-004 SHALL have I_LOCK  in  1  upstream valid/lock.
REQ-005 SHALL have I_ALUOut  in  `REG_WIDTH  ALU result or memory address.
REQ-006 SHALL have I_Opcode  in  `OPCODE_WIDTH  instruction opcode.
REQ-007 SHALL have I_DestRegIdx  in  4  destination register index.
REQ-008 SHALL have I_DestValue  in  `REG_WIDTH  store data / branch target.
REQ-009 SHALL have I_FetchStall, I_DepStall  in  1 each  upstream bubble flags.
REQ-010 SHALL have I_DMemAck  in  1  data-memory completion strobe.
REQ-011 SHALL have I_DMemRData  in  `REG_WIDTH  data-memory read data.
REQ-012 SHALL have O_DMemReq, O_DMemWe  out  1 each  memory request, write enable.
REQ-013 SHALL have O_DMemAddr, O_DMemWData  out  `REG_WIDTH each  address, write data.
REQ-014 SHALL have O_LOCK, O_FetchStall, O_DepStall  out  1 each  to writeback.
REQ-015 SHALL have O_ALUOut, O_MemOut  out  `REG_WIDTH each  passed ALU result, load data.
REQ-016 SHALL have O_Opcode  out  `OPCODE_WIDTH; O_DestRegIdx  out  4.
REQ-017 SHALL have O_MemStall  out  1  backpressure to execute; O_MemErr  out  1  timeout pulse.

Function
REQ-018 SHALL implement FSM states IDLE, WAIT; all outputs registered.
REQ-019 IDLE, I_LOCK=1, both stall flags 0, opcode OP_LDW/OP_STW: SHALL set O_DMemReq=1, O_DMemAddr=I_ALUOut, O_DMemWe=1 only for OP_STW, O_DMemWData=I_DestValue, O_MemStall=1, latch opcode/DestRegIdx, go WAIT.
REQ-020 IDLE, I_LOCK=1, no stall, any other opcode: SHALL forward I_ALUOut, I_Opcode, I_DestRegIdx next edge (1-cycle latency), O_DepStall=0.
REQ-021 IDLE, either stall flag 1: SHALL forward flags unchanged, leave data outputs unchanged, issue no request.
REQ-022 O_LOCK SHALL equal I_LOCK sampled on previous edge in IDLE; SHALL stay 1 in WAIT.
REQ-023 WAIT: request outputs SHALL stay stable; O_DepStall=1 (bubble) each edge; upstream holds inputs while O_MemStall=1.
REQ-024 WAIT, I_DMemAck=1 sampled: SHALL drop O_DMemReq/O_DMemWe, O_MemStall=0, O_DepStall=0, emit latched opcode/DestRegIdx, O_MemOut=I_DMemRData for OP_LDW (unchanged for OP_STW), go IDLE.
REQ-025 Minimum memory-op latency SHALL be 2 edges (issue, ack); I_DMemAck in IDLE SHALL be ignored.
REQ-026 Inputs arriving while in WAIT SHALL not be consumed; the held instruction is accepted on the first IDLE edge.

Reset
REQ-027 I_RESET=1 on a falling edge SHALL force IDLE and zero every output, including mid-WAIT (request dropped that edge, any later ack ignored).
REQ-028 Timeout counter SHALL clear on reset and on every WAIT entry.

Configuration
REQ-029 With MEM_STAGE_TIMEOUT_EN defined: counter increments per WAIT edge without ack; on reaching ACK_TIMEOUT SHALL drop request, pulse O_MemErr one cycle, emit bubble (O_DepStall=1), clear O_MemStall, go IDLE.
REQ-030 Without MEM_STAGE_TIMEOUT_EN: WAIT SHALL persist until ack; O_MemErr tied 0; no counter logic.
REQ-031 Ack on the same edge as timeout expiry SHALL take precedence (normal completion, no O_MemErr).

Verification
REQ-032 ADDI result 0x0005, dest R3 -> next edge O_ALUOut=0x0005, O_DestRegIdx=3, O_DepStall=0, no O_DMemReq.
REQ-033 LDW addr 0x0010, ack after 3 edges with RData 0xBEEF -> O_MemStall=1 for 3 edges, O_MemOut=0xBEEF, O_DestRegIdx latched.
REQ-034 STW addr 0x0020 data 0x1234, immediate ack -> O_DMemWe=1, O_DMemWData=0x1234 for one edge; 2-edge latency.
REQ-035 I_RESET asserted 2 edges into LDW WAIT, ack afterwards -> all outputs 0, state IDLE, ack ignored.
REQ-036 MEM_STAGE_TIMEOUT_EN, ACK_TIMEOUT=4, no ack -> O_MemErr pulses once after 4 WAIT edges, request dropped.
REQ-037 I_DepStall=1 with OP_LDW -> no request, O_DepStall=1 forwarded.
